// File: rtl/elevator_scan_controller_if.sv
// Car control bus: request intake, door sensors, and car status.
// The controller takes the slave side; a supervisor or bench takes the master side.
interface elevator_scan_controller_if #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = 3
);
  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic               over_time;
  logic               over_weight;
  logic [FLOOR_W-1:0] out_current_floor;
  logic               direction;
  logic               moving;
  logic               door_open;
  logic               complete;
  logic               door_alert;
  logic               weigh_alert;
  logic [FLOORS-1:0]  pending;

  modport master (
    output req_valid, req_floor, over_time, over_weight,
    input  out_current_floor, direction, moving, door_open, complete,
           door_alert, weigh_alert, pending
  );

  modport slave (
    input  req_valid, req_floor, over_time, over_weight,
    output out_current_floor, direction, moving, door_open, complete,
           door_alert, weigh_alert, pending
  );
endinterface

// File: rtl/elevator_scan_controller.sv
// N-floor SCAN elevator controller: pending request bitmap, timed floor moves,
// timed door dwell with overweight/obstruction hold.
//   state | meaning
//   IDLE  | parked, door closed, nothing pending
//   MOVE  | travelling one floor per MOVE_CYCLES in direction
//   DOOR  | door open at current floor, dwell timer running unless held
module elevator_scan_controller #(
  parameter int FLOORS      = 8,
  parameter int FLOOR_W     = 3,
  parameter int RESET_FLOOR = 0,
  parameter int MOVE_CYCLES = 2,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  elevator_scan_controller_if.slave  bus
);

  localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] MOVE_LOAD = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t             state;
  logic [FLOOR_W-1:0] cur_floor;
  logic               dir;
  logic               moving;
  logic               door_open;
  logic               complete;
  logic               door_alert;
  logic               weigh_alert;
  logic [FLOORS-1:0]  pending;
  logic [CNT_W-1:0]   move_cnt;
  logic [CNT_W-1:0]   door_cnt;

  logic               req_ok;
  logic               same_floor_req;
  logic               hold;
  logic               pend_here;
  logic               pend_ahead;
  logic               pend_behind;
  logic [FLOORS-1:0]  set_vec;
  logic [FLOORS-1:0]  cur_bit;
  logic [FLOORS-1:0]  next_bit;
  logic [FLOORS-1:0]  above;
  logic [FLOORS-1:0]  below;
  logic [FLOOR_W-1:0] next_floor;

  always_comb begin
    above = '0;
    below = '0;
    for (int i = 0; i < FLOORS; i++) begin
      above[i] = i > int'(cur_floor);
      below[i] = i < int'(cur_floor);
    end
  end

  // A request for the floor whose door is open is answered in place, never latched.
  assign req_ok         = bus.req_valid && (int'(bus.req_floor) < FLOORS);
  assign same_floor_req = req_ok && (state == DOOR) && (bus.req_floor == cur_floor);
  assign set_vec        = (req_ok && !same_floor_req) ? (FLOORS'(1) << bus.req_floor) : '0;

  assign cur_bit     = FLOORS'(1) << cur_floor;
  assign next_floor  = dir ? (cur_floor + FLOOR_W'(1)) : (cur_floor - FLOOR_W'(1));
  assign next_bit    = FLOORS'(1) << next_floor;
  assign pend_here   = |(pending & cur_bit);
  assign pend_ahead  = |(pending & (dir ? above : below));
  assign pend_behind = |(pending & (dir ? below : above));
  assign hold        = bus.over_time || bus.over_weight;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cur_floor   <= FLOOR_W'(RESET_FLOOR);
      dir         <= 1'b1;
      moving      <= 1'b0;
      door_open   <= 1'b0;
      complete    <= 1'b0;
      door_alert  <= 1'b0;
      weigh_alert <= 1'b0;
      pending     <= '0;
      move_cnt    <= '0;
      door_cnt    <= '0;
    end else begin
      complete    <= 1'b0;
      door_alert  <= (state == DOOR) && bus.over_time;
      weigh_alert <= (state == DOOR) && bus.over_weight;
      pending     <= pending | set_vec;
      case (state)
        IDLE: begin
          if (pend_here) begin
            state     <= DOOR;
            door_open <= 1'b1;
            door_cnt  <= DOOR_LOAD;
            complete  <= 1'b1;
            pending   <= (pending | set_vec) & ~cur_bit;
          end else if (pend_ahead || pend_behind) begin
            state    <= MOVE;
            moving   <= 1'b1;
            move_cnt <= MOVE_LOAD;
            if (!pend_ahead) dir <= ~dir;
          end
        end
        MOVE: begin
          if (move_cnt != '0) begin
            move_cnt <= move_cnt - CNT_W'(1);
          end else if (!pend_ahead) begin
            // Never step without a target ahead; keeps the car inside 0..FLOORS-1.
            state  <= IDLE;
            moving <= 1'b0;
          end else begin
            cur_floor <= next_floor;
            if (|(pending & next_bit)) begin
              state     <= DOOR;
              moving    <= 1'b0;
              door_open <= 1'b1;
              door_cnt  <= DOOR_LOAD;
              complete  <= 1'b1;
              pending   <= (pending | set_vec) & ~next_bit;
            end else begin
              move_cnt <= MOVE_LOAD;
            end
          end
        end
        DOOR: begin
          if (same_floor_req) begin
            door_cnt <= DOOR_LOAD;
            complete <= 1'b1;
          end else if (!hold) begin
            if (door_cnt != '0) begin
              door_cnt <= door_cnt - CNT_W'(1);
            end else begin
              door_open <= 1'b0;
              if (pend_ahead || pend_behind) begin
                state    <= MOVE;
                moving   <= 1'b1;
                move_cnt <= MOVE_LOAD;
                if (!pend_ahead) dir <= ~dir;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_current_floor = cur_floor;
  assign bus.direction         = dir;
  assign bus.moving            = moving;
  assign bus.door_open         = door_open;
  assign bus.complete          = complete;
  assign bus.door_alert        = door_alert;
  assign bus.weigh_alert       = weigh_alert;
  assign bus.pending           = pending;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Bench for elevator_scan_controller: directed trips with a completion scoreboard
// holding the expected (floor, cycle) of every complete pulse.
module tb_elevator_scan_controller;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   t0;

  typedef struct {
    int floor;
    int cyc;
  } exp_t;
  exp_t sb[$];

  elevator_scan_controller_if #(.FLOORS(6), .FLOOR_W(3)) ifc ();

  elevator_scan_controller #(
    .FLOORS(6), .FLOOR_W(3), .RESET_FLOOR(0), .MOVE_CYCLES(2), .DOOR_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int f);
    ifc.req_valid = 1'b1;
    ifc.req_floor = 3'(f);
    tick();
    ifc.req_valid = 1'b0;
  endtask

  task automatic push(input int f, input int c);
    exp_t e;
    e.floor = f;
    e.cyc   = c;
    sb.push_back(e);
  endtask

  // Every complete pulse must match the oldest expected service.
  always @(negedge clk) begin
    if (reset && ifc.complete) begin
      if (sb.size() == 0) begin
        chk("spurious_complete", ifc.complete, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_floor", ifc.out_current_floor, e.floor);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cyc   = 0;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    ifc.req_valid   = 1'b0;
    ifc.req_floor   = '0;
    ifc.over_time   = 1'b0;
    ifc.over_weight = 1'b0;

    // reset state
    #12;
    chk("rst_floor", ifc.out_current_floor, 0);
    chk("rst_dir", ifc.direction, 1);
    chk("rst_pending", ifc.pending, 0);
    chk("rst_moving", ifc.moving, 0);
    chk("rst_door", ifc.door_open, 0);
    chk("rst_complete", ifc.complete, 0);
    chk("rst_door_alert", ifc.door_alert, 0);
    chk("rst_weigh_alert", ifc.weigh_alert, 0);
    reset = 1'b1;
    tick();

    // single trip 0 -> 5
    send(5);
    t0 = cyc;
    push(5, t0 + 11);
    chk("trip_pending", ifc.pending, 6'b100000);
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk("trip_floor", ifc.out_current_floor, (e >= 11) ? 5 : (e - 1) / 2);
      chk("trip_door", ifc.door_open, (e >= 11 && e <= 14));
      chk("trip_moving", ifc.moving, (e >= 1 && e <= 10));
    end
    chk("trip_pending_end", ifc.pending, 0);

    // back to floor 0 through reset
    reset = 1'b0;
    #3;
    reset = 1'b1;
    tick();
    chk("rerst_floor", ifc.out_current_floor, 0);

    // SCAN order: 3, then 5, then reverse for 1
    send(3);
    t0 = cyc;
    push(3, t0 + 7);
    push(5, t0 + 15);
    push(1, t0 + 27);
    ticks(3);
    chk("scan_floor1", ifc.out_current_floor, 1);
    send(1);
    send(5);
    chk("scan_pending", ifc.pending, 6'b101010);
    ticks(15);
    chk("scan_rev_dir", ifc.direction, 0);
    chk("scan_rev_moving", ifc.moving, 1);
    chk("scan_rev_floor", ifc.out_current_floor, 5);
    ticks(11);
    chk("scan_end_floor", ifc.out_current_floor, 1);
    chk("scan_end_pending", ifc.pending, 0);
    chk("scan_end_door", ifc.door_open, 0);
    chk("scan_end_moving", ifc.moving, 0);

    // overweight hold at floor 0
    send(0);
    t0 = cyc;
    push(0, t0 + 3);
    ticks(3);
    chk("ow_open", ifc.door_open, 1);
    tick();
    ifc.over_weight = 1'b1;
    for (int e = 5; e <= 14; e++) begin
      tick();
      chk("ow_alert", ifc.weigh_alert, 1);
      chk("ow_door", ifc.door_open, 1);
      chk("ow_floor", ifc.out_current_floor, 0);
      chk("ow_door_alert", ifc.door_alert, 0);
    end
    ifc.over_weight = 1'b0;
    tick();
    chk("ow_alert_clr", ifc.weigh_alert, 0);
    chk("ow_door15", ifc.door_open, 1);
    tick();
    chk("ow_door16", ifc.door_open, 1);
    tick();
    chk("ow_door17", ifc.door_open, 0);

    // same-floor request while open, obstruction, invalid floors
    send(0);
    t0 = cyc;
    push(0, t0 + 1);
    tick();
    chk("sf_open", ifc.door_open, 1);
    tick();
    send(0);
    push(0, t0 + 3);
    chk("sf_pending", ifc.pending, 0);
    ifc.over_time = 1'b1;
    tick();
    chk("ot_alert", ifc.door_alert, 1);
    ifc.over_time = 1'b0;
    tick();
    chk("ot_alert_clr", ifc.door_alert, 0);
    ticks(2);
    chk("sf_door7", ifc.door_open, 1);
    tick();
    chk("sf_door8", ifc.door_open, 0);
    send(7);
    chk("inv7_pending", ifc.pending, 0);
    send(6);
    chk("inv6_pending", ifc.pending, 0);
    tick();
    chk("inv_moving", ifc.moving, 0);
    chk("inv_door", ifc.door_open, 0);

    // async reset mid-move
    send(4);
    ticks(5);
    chk("ar_pre_floor", ifc.out_current_floor, 2);
    chk("ar_pre_moving", ifc.moving, 1);
    chk("ar_pre_dir", ifc.direction, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_floor", ifc.out_current_floor, 0);
    chk("ar_moving", ifc.moving, 0);
    chk("ar_pending", ifc.pending, 0);
    chk("ar_dir", ifc.direction, 1);
    chk("ar_door", ifc.door_open, 0);
    #2;
    reset = 1'b1;
    ticks(3);
    chk("ar_idle_moving", ifc.moving, 0);
    chk("sb_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/elevator_scan_controller.md
# elevator_scan_controller

Parametrised N-floor elevator controller. It latches floor requests into a pending bitmap and services them in SCAN (sweep) order with a timed car move and a timed door dwell. It holds the door on overweight or door-obstruction conditions and raises the matching alerts. It succeeds the fixed 4-bit single-request elevator controller and is the top-level car control block.

## Interface
- FLOORS, 8, number of floors (2..2**FLOOR_W); floors numbered 0..FLOORS-1
- FLOOR_W, 3, floor index width
- RESET_FLOOR, 0, car position after reset
- MOVE_CYCLES, 2, clock cycles per one-floor move (>=1)
- DOOR_CYCLES, 4, door dwell cycles when not held (>=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request strobe, sampled each rising edge
- req_floor  in  FLOOR_W  requested floor
- over_time  in  1  door obstruction (door held too long)
- over_weight  in  1  car overloaded
- out_current_floor  out  FLOOR_W  car position
- direction  out  1  sweep direction; 1 = up, 0 = down
- moving  out  1  car is between floors (state MOVE)
- door_open  out  1  state DOOR
- complete  out  1  one-cycle pulse on servicing a request
- door_alert  out  1  over_time sampled high while in DOOR
- weigh_alert  out  1  over_weight sampled high while in DOOR
- pending  out  FLOORS  outstanding request bitmap

## Operation
- Reset values: out_current_floor=RESET_FLOOR, direction=1, pending=0, state IDLE. All other outputs are 0.
- Request intake: at an edge with req_valid=1 and req_floor<FLOORS, set pending[req_floor].
  - req_floor>=FLOORS: ignored.
  - Request equal to the current floor while in DOOR, or while arriving at that floor: not latched. Pulse complete and reload the door timer.
- IDLE: state is entered only after a door close or a move with no pending requests.
  - If pending has a bit at the current floor: go to DOOR, clear the bit, pulse complete.
  - Else if pending has a bit above: direction=1, go to MOVE.
  - Else if pending has a bit below: direction=0, go to MOVE.
  - Preference is to continue the current direction first.
- MOVE:
  - Move counter loads MOVE_CYCLES-1 on entry and decrements each edge.
  - At an edge where the counter is 0, the floor steps by ±1.
  - If pending[new floor] is set: go to DOOR, clear the bit, pulse complete.
  - Otherwise reload the counter and continue.
  - over_time and over_weight are ignored in MOVE.
- DOOR:
  - Door timer loads DOOR_CYCLES-1 on entry.
  - The timer decrements only at edges where over_time=0 and over_weight=0. A held timer keeps its value.
  - At an edge with timer 0 and no hold: if pending is nonzero ahead in the current direction, go to MOVE keeping direction. Else if pending is nonzero behind, flip direction and go to MOVE. Else go to IDLE.
- Alerts are registered and track the sampled input only while in DOOR. They clear on the edge after the input falls or DOOR is exited.
- The car never moves past floor 0 or floor FLOORS-1. Direction always points toward a pending bit when entering MOVE.

## Timing
- Request to pending bit visible: 1 cycle.
- IDLE to MOVE: 1 edge after pending becomes nonzero.
- Floor update: MOVE_CYCLES edges after MOVE entry, and every MOVE_CYCLES thereafter.
- Arrival edge: out_current_floor, door_open=1, complete=1, and the pending bit clear all update together. complete drops on the next edge.
- door_open stays high exactly DOOR_CYCLES cycles unheld, plus one cycle per held edge.
- Simultaneous new request for a floor being cleared on the same edge: absorbed (bit stays 0).
- reset low at any time (including mid-MOVE or mid-DOOR): all registers return to reset values immediately. The pending bitmap is lost.

## Test plan
Bench parameters: FLOORS=6, FLOOR_W=3, MOVE_CYCLES=2, DOOR_CYCLES=4, RESET_FLOOR=0.
- Reset: hold reset=0 -> floor=0, direction=1, pending=0, moving=0, door_open=0, complete=0, both alerts 0.
- Single trip: request floor 5 at edge 0 -> pending=6'b100000 after edge 0. MOVE at edge 1. Floor steps 1..5 at edges 3,5,7,9,11. complete pulses at edge 11. door_open high for 4 cycles, edges 11-15. Then IDLE with pending=0.
- SCAN order: at floor 0 request 3; when floor=1 request 1 and 5 -> floor 1 is already passed, so service 3, then 5. Then reverse (direction=0) and service 1. Three complete pulses in order 3, 5, 1.
- Overweight hold: over_weight=1 for 10 cycles starting 1 cycle after door opens -> weigh_alert=1, door_open stays high, floor unchanged. After release, door closes after the remaining 3 timer cycles.
- Same-floor and invalid requests: request the current floor while door_open -> complete pulse, timer reloads, pending unchanged. Request floor 7 -> ignored, pending unchanged.
- Async reset mid-move: assert reset low between edges while floor=2 moving up -> floor=0, moving=0, pending=0 immediately, with no clock edge needed.
